fir_coeff_host: RTL and testbench

Initiator side of the serial FIR coefficient link. It converts a parallel 64-bit word request into the one-bit `coeff_req` / `coeff_wr_op` / `coeff_wr_data` / `coeff_ack` / `coeff_rd_data` transaction that `fir_coeff_master` answers, and returns read data in parallel. It sits on the control side of the board, for example in the slow-control FPGA or a test harness, and drives the serial pins that feed `top`.

---
 rtl/fir_coeff_host_if.sv | 35 +++
 rtl/fir_coeff_host.sv | 149 ++++++++++++++
 tb/tb_fir_coeff_host.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_host_if.sv
// Signal bundle between the parallel request side and the serial coefficient
// link of fir_coeff_host.
//   start/op/wdata        : one-cycle word request (op 1 = write, 0 = read)
//   busy/done/err/rdata   : transaction status and last successfully read word
//   coeff_req/coeff_wr_op : transaction strobe and operation type to the master
//   coeff_wr_data         : serial write data, MSB first
//   coeff_ack             : acknowledge pulse from the master
//   coeff_rd_data         : serial read data, MSB first
// master modport = fir_coeff_host side, slave modport = requester/responder side.
interface fir_coeff_host_if #(
   parameter int WORD_W = 64
);
   logic              start;
   logic              op;
   logic [WORD_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [WORD_W-1:0] rdata;
   logic              coeff_req;
   logic              coeff_wr_op;
   logic              coeff_wr_data;
   logic              coeff_ack;
   logic              coeff_rd_data;

   modport master (
      input  start, op, wdata, coeff_ack, coeff_rd_data,
      output busy, done, err, rdata, coeff_req, coeff_wr_op, coeff_wr_data
   );

   modport slave (
      output start, op, wdata, coeff_ack, coeff_rd_data,
      input  busy, done, err, rdata, coeff_req, coeff_wr_op, coeff_wr_data
   );
endinterface

// File: rtl/fir_coeff_host.sv
// Initiator of the serial FIR coefficient link. Turns a parallel word request
// into the one-bit req/wr_op/wr_data/ack/rd_data transaction and returns read
// words in parallel.
// Ports:
//   OSC_60MHZ : system clock, rising edge
//   RESET     : synchronous active-high reset
//   bus       : fir_coeff_host_if master modport (request, status, serial link)
// All outputs are registered.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// W_SHIFT | write word on coeff_wr_data, MSB first, one bit per cycle
// W_ACK   | write sent, waiting for ack or timeout
// R_ACK   | read requested, waiting for ack or timeout
// R_SHIFT | sampling coeff_rd_data, MSB first
// GAP     | done cycle, coeff_req low; a held start launches from here
module fir_coeff_host #(
   parameter int WORD_W  = 64,
   parameter int TIMEOUT = 255
) (
   input logic              OSC_60MHZ,
   input logic              RESET,
   fir_coeff_host_if.master bus
);
   localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
   localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] W_SHIFT = 3'd1;
   localparam logic [2:0] W_ACK   = 3'd2;
   localparam logic [2:0] R_ACK   = 3'd3;
   localparam logic [2:0] R_SHIFT = 3'd4;
   localparam logic [2:0] GAP     = 3'd5;

   logic [2:0]        state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [15:0]       tmo_cnt;

   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [WORD_W-1:0] rdata_q;
   logic              req_q;
   logic              wr_op_q;
   logic              wr_data_q;

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.rdata         = rdata_q;
   assign bus.coeff_req     = req_q;
   assign bus.coeff_wr_op   = wr_op_q;
   assign bus.coeff_wr_data = wr_data_q;

   always_ff @(posedge OSC_60MHZ) begin
      if (RESET) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         req_q     <= 1'b0;
         wr_op_q   <= 1'b0;
         wr_data_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         case (state)
            // GAP is already the guaranteed low cycle on coeff_req, so a start
            // sampled at its closing edge yields exactly one low cycle between
            // back-to-back transactions.
            IDLE, GAP: begin
               if (bus.start) begin
                  // MSB goes out right away; shreg holds the remaining bits.
                  shreg     <= {bus.wdata[WORD_W-2:0], 1'b0};
                  wr_data_q <= bus.op & bus.wdata[WORD_W-1];
                  wr_op_q   <= bus.op;
                  req_q     <= 1'b1;
                  busy_q    <= 1'b1;
                  bit_cnt   <= '0;
                  tmo_cnt   <= '0;
                  state     <= bus.op ? W_SHIFT : R_ACK;
               end else begin
                  state <= IDLE;
               end
            end

            W_SHIFT: begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  wr_data_q <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= W_ACK;
               end else begin
                  wr_data_q <= shreg[WORD_W-1];
                  shreg     <= {shreg[WORD_W-2:0], 1'b0};
               end
            end

            W_ACK, R_ACK: begin
               if (bus.coeff_ack) begin
                  if (state == W_ACK) begin
                     done_q <= 1'b1;
                     req_q  <= 1'b0;
                     busy_q <= 1'b0;
                     state  <= GAP;
                  end else begin
                     bit_cnt <= '0;
                     state   <= R_SHIFT;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // tmo_cnt counts edges already waited; this one is the
                  // TIMEOUT-th, so done/err land TIMEOUT cycles after entry.
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                  req_q  <= 1'b0;
                  busy_q <= 1'b0;
                  state  <= GAP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            R_SHIFT: begin
               shreg   <= {shreg[WORD_W-2:0], bus.coeff_rd_data};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  rdata_q <= {shreg[WORD_W-2:0], bus.coeff_rd_data};
                  done_q  <= 1'b1;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= GAP;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fir_coeff_host.sv
// Testbench for fir_coeff_host: the stimulus pushes a responder plan and an
// expected response per transaction; a responder process plays the serial
// master, and a monitor process pops and compares on every done.
module tb_fir_coeff_host;
   localparam int W   = 64;
   localparam int TMO = 255;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fir_coeff_host_if #(.WORD_W(W)) bus ();

   fir_coeff_host #(.WORD_W(W), .TIMEOUT(TMO)) dut (
      .OSC_60MHZ (clk),
      .RESET     (rst),
      .bus       (bus)
   );

   // k = 1-based ack-state cycle in which ack is given, 0 = never ack
   typedef struct {
      bit           wr;
      logic [W-1:0] wword;
      logic [W-1:0] rword;
      int           k;
      int           spur;
   } rcfg_t;

   typedef struct {
      logic         err;
      logic [W-1:0] rdata;
      int           req_hi;
   } exp_t;

   rcfg_t        rq[$];
   exp_t         sb[$];
   logic [W-1:0] model_rd;
   int           n_pass  = 0;
   int           n_total = 0;
   bit           gap_chk = 1'b0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b required %b", name, act, exp);
   endtask

   task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic fail_now(input string name, input int waited);
      n_total++;
      $display("FAIL %s: waited %0d cycles, required event never came", name, waited);
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_busy"},  bus.busy,          1'b0);
      chk1({tag, "_done"},  bus.done,          1'b0);
      chk1({tag, "_err"},   bus.err,           1'b0);
      chk1({tag, "_req"},   bus.coeff_req,     1'b0);
      chk1({tag, "_wrop"},  bus.coeff_wr_op,   1'b0);
      chk1({tag, "_wrdat"}, bus.coeff_wr_data, 1'b0);
      chkw({tag, "_rdata"}, bus.rdata,         '0);
   endtask

   // Reference model: expected outcome from the link rules alone.
   task automatic plan(input bit wr, input logic [W-1:0] ww, input logic [W-1:0] rw,
                       input int k, input int spur);
      rcfg_t c;
      exp_t  e;
      c.wr = wr; c.wword = ww; c.rword = rw; c.k = k; c.spur = spur;
      rq.push_back(c);
      e.err = (k == 0);
      if (k == 0) e.req_hi = wr ? (W + TMO) : TMO;
      else        e.req_hi = W + k;
      if (!wr && k != 0) model_rd = rw;
      e.rdata = model_rd;
      sb.push_back(e);
   endtask

   task automatic wait_sb(input int n, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() <= n) return;
      end
      fail_now("wait_done", bound);
   endtask

   task automatic wait_req_low(input int bound);
      int n = 0;
      while (bus.coeff_req) begin
         if (n >= bound) begin
            fail_now("req_low", n);
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run(input bit wr, input logic [W-1:0] ww, input logic [W-1:0] rw,
                      input int k, input int spur, input bit spur_start);
      plan(wr, ww, rw, k, spur);
      @(negedge clk);
      bus.start = 1'b1; bus.op = wr; bus.wdata = ww;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 1'($urandom); bus.wdata = {$urandom, $urandom};
      if (spur_start) begin
         repeat (20) @(negedge clk);
         bus.start = 1'b1; bus.op = ~wr; bus.wdata = {$urandom, $urandom};
         @(negedge clk);
         bus.start = 1'b0;
      end
      wait_sb(0, 1000);
   endtask

   // ---------------- responder (serial master model) ----------------
   task automatic serve_write(input rcfg_t c);
      logic [W-1:0] cap = '0;
      for (int i = 0; i < W; i++) begin
         if (i > 0 && !bus.coeff_req) begin
            bus.coeff_ack = 1'b0;
            return;
         end
         cap[W-1-i]    = bus.coeff_wr_data;
         bus.coeff_ack = (i == c.spur);
         @(negedge clk);
      end
      bus.coeff_ack = 1'b0;
      chkw("wr_word", cap, c.wword);
      chk1("wr_data_after_shift", bus.coeff_wr_data, 1'b0);
      if (c.k == 0) begin
         wait_req_low(TMO + 10);
      end else begin
         repeat (c.k - 1) @(negedge clk);
         bus.coeff_ack = 1'b1;
         @(negedge clk);
         bus.coeff_ack = 1'b0;
      end
   endtask

   task automatic serve_read(input rcfg_t c);
      if (c.k == 0) begin
         wait_req_low(TMO + 10);
         return;
      end
      for (int j = 1; j < c.k; j++) begin
         bus.coeff_rd_data = 1'($urandom);
         @(negedge clk);
      end
      bus.coeff_ack = 1'b1;
      @(negedge clk);
      bus.coeff_ack = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (!bus.coeff_req) begin
            bus.coeff_rd_data = 1'b0;
            return;
         end
         bus.coeff_rd_data = c.rword[W-1-i];
         @(negedge clk);
      end
      bus.coeff_rd_data = 1'b0;
   endtask

   initial begin
      rcfg_t c;
      bus.coeff_ack     = 1'b0;
      bus.coeff_rd_data = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.coeff_req && !rst) begin
            if (rq.size() == 0) begin
               n_total++;
               $display("FAIL unplanned_req: got req=1 required req=0");
               wait_req_low(2000);
            end else begin
               c = rq.pop_front();
               chk1("wr_op", bus.coeff_wr_op, c.wr);
               chk1("busy_at_req", bus.busy, 1'b1);
               if (c.wr) serve_write(c);
               else      serve_read(c);
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      bit   prev = 1'b0;
      int   hi   = 0;
      int   lo   = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0; hi = 0; lo = 0;
            continue;
         end
         if (bus.coeff_req) begin
            if (!prev) begin
               if (gap_chk) begin
                  chki("b2b_req_low_cycles", lo, 1);
                  gap_chk = 1'b0;
               end
               hi = 0;
            end
            hi++;
         end else begin
            if (prev) lo = 0;
            lo++;
         end
         prev = bus.coeff_req;
         if (bus.done) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_done: got done=1 required done=0");
            end else begin
               e = sb.pop_front();
               chk1("err", bus.err, e.err);
               chkw("rdata", bus.rdata, e.rdata);
               chk1("req_low_at_done", bus.coeff_req, 1'b0);
               chki("req_high_cycles", hi, e.req_hi);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit seen_done;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.wdata = '0;
      model_rd  = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      run(1'b1, 64'hDEAD_BEEF_0123_4567, '0, 4, -1, 1'b0);
      run(1'b0, {$urandom, $urandom}, 64'h0000_0001_8000_0000, 6, -1, 1'b0);
      run(1'b1, 64'hA5A5_5A5A_F00D_CAFE, '0, 0, -1, 1'b0);
      run(1'b0, '0, 64'hFFFF_0000_FFFF_0000, 0, -1, 1'b0);
      run(1'b1, 64'h0123_4567_89AB_CDEF, '0, 7, 10, 1'b1);
      run(1'b1, 64'h8000_0000_0000_0001, '0, 1, -1, 1'b0);

      // reset while the read is sampling bit 20
      plan(1'b0, '0, 64'hC3C3_3C3C_1234_5678, 2, -1);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2 + 20) @(negedge clk);
      sb.delete();
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      model_rd = '0;
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      chk1("no_done_after_reset", seen_done, 1'b0);
      run(1'b1, 64'h5555_AAAA_3333_CCCC, '0, 3, -1, 1'b0);

      // back-to-back writes with start held high
      plan(1'b1, 64'h1, '0, 2, -1);
      plan(1'b1, 64'h2, '0, 1, -1);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 1'b1; bus.wdata = 64'h1;
      @(negedge clk);
      bus.wdata = 64'h2;
      wait_sb(1, 1000);
      gap_chk = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_sb(0, 1000);

      for (int t = 0; t < 12; t++) begin
         bit wr;
         int k;
         wr = 1'($urandom_range(0, 1));
         k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
         run(wr, {$urandom, $urandom}, {$urandom, $urandom}, k,
             wr ? int'($urandom_range(0, W - 1)) : -1, 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of run, required finish");
      $fatal(1, "watchdog expired");
   end
endmodule
